// File: rtl/branch_predictor_pkg.sv
// -----------------------------------------------------------------------------
// branch_predictor_pkg
// Shared datatypes for the branch predictor slice:
//   ctr_state_t   - 2-bit saturating counter state held per table entry
//   branch_func_t - branch func encodings used by the branch evaluator
//   COUNT_W       - width of the mispredict counter
// -----------------------------------------------------------------------------
package branch_predictor_pkg;

    // Counter state; bit [1] is the predicted direction.
    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_state_t;

    // Branch func field encodings; the unused codes are reserved and make the
    // evaluator raise its exception output.
    typedef enum logic [2:0] {
        FUNC_BEQ  = 3'b000,
        FUNC_BNE  = 3'b001,
        FUNC_BLT  = 3'b100,
        FUNC_BGE  = 3'b101,
        FUNC_BLTU = 3'b110,
        FUNC_BGEU = 3'b111
    } branch_func_t;

    localparam int COUNT_W = 16;

endpackage

// File: rtl/branch_predictor_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_if
// Bundles the lookup, prediction, update and mispredict signals.
//   master : fetch/evaluator side (drives req_* and upd_*)
//   slave  : predictor side (drives pred_*, mispredict, mispredict_count)
// Parameter WIDTH is the PC width in bits.
// -----------------------------------------------------------------------------
interface branch_predictor_if
    import branch_predictor_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic               req_valid;
    logic [WIDTH-1:0]   req_pc;
    logic               pred_valid;
    logic               pred_taken;
    logic               upd_valid;
    logic [WIDTH-1:0]   upd_pc;
    logic               upd_taken;
    logic               upd_exception;
    logic               upd_pred;
    logic               mispredict;
    logic [COUNT_W-1:0] mispredict_count;

    modport master (
        output req_valid, req_pc,
        output upd_valid, upd_pc, upd_taken, upd_exception, upd_pred,
        input  pred_valid, pred_taken, mispredict, mispredict_count
    );

    modport slave (
        input  req_valid, req_pc,
        input  upd_valid, upd_pc, upd_taken, upd_exception, upd_pred,
        output pred_valid, pred_taken, mispredict, mispredict_count
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// -----------------------------------------------------------------------------
// sat_counter2
// Combinational next-state for a 2-bit saturating counter.
//   state      : current counter state
//   taken      : resolved direction (1 counts up, 0 counts down)
//   next_state : updated state, saturating at SNT and ST
// -----------------------------------------------------------------------------
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_state_t state,
    input  logic       taken,
    output ctr_state_t next_state
);
    always_comb begin
        next_state = state;
        case (state)
            SNT:     next_state = taken ? WNT : SNT;
            WNT:     next_state = taken ? WT  : SNT;
            WT:      next_state = taken ? ST  : WNT;
            ST:      next_state = taken ? ST  : WT;
            default: next_state = state;
        endcase
    end
endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Bimodal branch predictor: a table of ENTRIES 2-bit saturating counters
// indexed by pc[log2(ENTRIES)+1:2].
//   clk  : clock, all state changes on its rising edge
//   rst  : asynchronous active-high reset (table to WNT, outputs to 0)
//   bus  : branch_predictor_if.slave
//          req_valid/req_pc       -> pred_valid/pred_taken one cycle later
//          upd_valid/upd_pc/upd_taken/upd_exception/upd_pred
//                                 -> table update, mispredict pulse and
//                                    saturating mispredict_count
// Lookups read the table before the same-edge update (no bypass).
// -----------------------------------------------------------------------------
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 16
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == {COUNT_W{1'b1}}) ? v : v + {{(COUNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [WIDTH-1:0]   req_pc_w;
    logic [WIDTH-1:0]   upd_pc_w;
    logic [IDX_W-1:0]   req_idx;
    logic [IDX_W-1:0]   upd_idx;
    logic               unused_pc_bits;

    ctr_state_t         bht [ENTRIES];
    ctr_state_t         upd_next;
    logic               upd_fire;
    logic               mis_det;

    logic               pred_valid_p1;
    logic               pred_taken_p1;
    logic               mispredict_p1;
    logic [COUNT_W-1:0] mis_count_p1;

    assign req_pc_w = bus.req_pc;
    assign upd_pc_w = bus.upd_pc;
    assign req_idx  = req_pc_w[IDX_W+1:2];
    assign upd_idx  = upd_pc_w[IDX_W+1:2];

    // Only the index field of each PC matters to the table.
    assign unused_pc_bits = ^{req_pc_w, upd_pc_w};

    // Exceptions (reserved func) never train the table or count as mispredicts.
    assign upd_fire = bus.upd_valid && !bus.upd_exception;
    assign mis_det  = upd_fire && (bus.upd_pred != bus.upd_taken);

    sat_counter2 u_sat (
        .state      (bht[upd_idx]),
        .taken      (bus.upd_taken),
        .next_state (upd_next)
    );

    // ---- stage p0 -> p1: table read/update and registered outputs ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= WNT;
            end
            pred_valid_p1 <= 1'b0;
            pred_taken_p1 <= 1'b0;
            mispredict_p1 <= 1'b0;
            mis_count_p1  <= '0;
        end else begin
            pred_valid_p1 <= bus.req_valid;
            if (bus.req_valid) begin
                pred_taken_p1 <= bht[req_idx][1];
            end
            if (upd_fire) begin
                bht[upd_idx] <= upd_next;
            end
            mispredict_p1 <= mis_det;
            if (mis_det) begin
                mis_count_p1 <= sat_inc(mis_count_p1);
            end
        end
    end

    assign bus.pred_valid       = pred_valid_p1;
    assign bus.pred_taken       = pred_taken_p1;
    assign bus.mispredict       = mispredict_p1;
    assign bus.mispredict_count = mis_count_p1;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
// Directed and randomized stimulus against a behavioural predictor model:
// integer counters 0..3 per entry, prediction = counter >= 2, and an integer
// mispredict count capped at 65535.
// -----------------------------------------------------------------------------
module tb_branch_predictor;
    localparam int WIDTH   = 32;
    localparam int ENTRIES = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    branch_predictor_if #(.WIDTH(WIDTH)) bus ();

    branch_predictor #(.WIDTH(WIDTH), .ENTRIES(ENTRIES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int model [ENTRIES];
    int cnt;
    bit exp_pv;
    bit exp_pt;
    bit exp_mis;

    function automatic int idx_of(input logic [WIDTH-1:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) model[i] = 1;
        cnt     = 0;
        exp_pv  = 1'b0;
        exp_pt  = 1'b0;
        exp_mis = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".pred_valid"}, 32'(bus.pred_valid), 32'(exp_pv));
        check({tag, ".pred_taken"}, 32'(bus.pred_taken), 32'(exp_pt));
        check({tag, ".mispredict"}, 32'(bus.mispredict), 32'(exp_mis));
        check({tag, ".count"}, 32'(bus.mispredict_count), 32'(cnt));
    endtask

    // Drive one cycle of inputs, advance the model, clock, then optionally check.
    task automatic cycle(input bit rv, input logic [WIDTH-1:0] rpc,
                         input bit uv, input logic [WIDTH-1:0] upc,
                         input bit ut, input bit ue, input bit up,
                         input bit chk, input string tag);
        int u;
        bus.req_valid     = rv;
        bus.req_pc        = rpc;
        bus.upd_valid     = uv;
        bus.upd_pc        = upc;
        bus.upd_taken     = ut;
        bus.upd_exception = ue;
        bus.upd_pred      = up;
        // Lookup sees the table as it was before this cycle's update.
        exp_pv = rv;
        if (rv) exp_pt = (model[idx_of(rpc)] >= 2);
        exp_mis = uv && !ue && (up != ut);
        if (exp_mis && cnt < 65535) cnt = cnt + 1;
        if (uv && !ue) begin
            u = idx_of(upc);
            if (ut) model[u] = (model[u] < 3) ? model[u] + 1 : 3;
            else    model[u] = (model[u] > 0) ? model[u] - 1 : 0;
        end
        @(posedge clk);
        #1;
        if (chk) check_outputs(tag);
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid     = 1'b1;
        bus.req_pc        = 32'h100;
        bus.upd_valid     = 1'b1;
        bus.upd_pc        = 32'h100;
        bus.upd_taken     = 1'b1;
        bus.upd_exception = 1'b0;
        bus.upd_pred      = 1'b0;
        model_reset();

        // Reset: traffic presented while rst is high is discarded.
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;
        cycle(0, 0, 0, 0, 0, 0, 0, 1, "post_reset_idle");

        // First lookup after reset: WNT predicts not taken.
        cycle(1, 32'h100, 0, 0, 0, 0, 0, 1, "lookup_0x100");
        check("lookup_0x100.const_taken", 32'(bus.pred_taken), 32'd0);

        // Two taken updates with wrong prediction: WNT -> WT -> ST.
        cycle(0, 0, 1, 32'h100, 1, 0, 0, 1, "upd1_0x100");
        cycle(0, 0, 1, 32'h100, 1, 0, 0, 1, "upd2_0x100");
        check("upd2_0x100.const_count", 32'(bus.mispredict_count), 32'd2);
        cycle(1, 32'h100, 0, 0, 0, 0, 0, 1, "lookup_0x100_taken");
        check("lookup_0x100_taken.const", 32'(bus.pred_taken), 32'd1);

        // Five not-taken updates at 0x104 saturate at SNT.
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 32'h104, 0, 0, 0, 1, "nt_0x104");
        cycle(1, 32'h104, 0, 0, 0, 0, 0, 1, "lookup_0x104");
        check("lookup_0x104.const", 32'(bus.pred_taken), 32'd0);

        // Exception update must not train entry 2 or count a mispredict.
        cycle(0, 0, 1, 32'h108, 1, 1, 0, 1, "exception_0x108");
        check("exception_0x108.const_mis", 32'(bus.mispredict), 32'd0);
        check("exception_0x108.const_count", 32'(bus.mispredict_count), 32'd2);
        cycle(1, 32'h108, 0, 0, 0, 0, 0, 1, "lookup_0x108");
        check("lookup_0x108.const", 32'(bus.pred_taken), 32'd0);

        // Bring entry 0 from ST to WT, then same-cycle lookup + not-taken update.
        cycle(0, 0, 1, 32'h100, 0, 0, 1, 1, "st_to_wt");
        cycle(1, 32'h140, 1, 32'h140, 0, 0, 1, 1, "same_cycle_0x140");
        check("same_cycle_0x140.const", 32'(bus.pred_taken), 32'd1);
        cycle(1, 32'h140, 0, 0, 0, 0, 0, 1, "after_0x140");
        check("after_0x140.const", 32'(bus.pred_taken), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            cycle(bit'($urandom_range(0, 1)), WIDTH'($urandom),
                  bit'($urandom_range(0, 1)), WIDTH'($urandom),
                  bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  bit'($urandom_range(0, 1)), 1, "random");
        end

        // Drive the mispredict counter to saturation.
        for (int i = 0; i < 65540; i++) begin
            cycle(1, 32'h180, 1, 32'h180, 1, 0, 0, (i >= 65530), "saturate");
        end
        check("saturate.const_count", 32'(bus.mispredict_count), 32'hFFFF);
        cycle(1, 32'h180, 0, 0, 0, 0, 0, 1, "hold_sat");
        check("hold_sat.const_count", 32'(bus.mispredict_count), 32'hFFFF);
        cycle(1, 32'h180, 1, 32'h180, 1, 0, 0, 1, "pre_async_rst");

        // Asynchronous reset mid-cycle: outputs clear without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge clk);
        #1;
        check_outputs("async_rst_held");
        rst = 1'b0;
        cycle(1, 32'h180, 0, 0, 0, 0, 0, 1, "lookup_after_rst");
        check("lookup_after_rst.const_valid", 32'(bus.pred_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
